// File: rtl/ram_prog_loader.sv
// Programming-mode front end for the program RAM. It streams bytes in over valid/ready,
// writes each byte to successive addresses, and can read each byte back to flag the first bad one.
module ram_prog_loader #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter bit VERIFY = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [ADDR_W-1:0] addr,
   output logic              ram_write,
   output logic              ram_read,
   inout  wire  [DATA_W-1:0] bus,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] err_addr
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WRITE,
      S_READ,
      S_CHECK,
      S_DONE
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [DATA_W-1:0] hold;
   logic              accept_start;
   logic              capture;
   logic              compare;
   logic              advance;
   logic              last_addr;
   logic              mismatch;

   assign last_addr = &addr;
   assign mismatch  = (bus != hold);

   // The bus is driven only while writing; in CHECK the RAM owns it.
   assign bus = (state == S_WRITE) ? hold : {DATA_W{1'bz}};

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      next_state   = state;
      in_ready     = 1'b0;
      ram_write    = 1'b0;
      ram_read     = 1'b0;
      busy         = 1'b1;
      done         = 1'b0;
      accept_start = 1'b0;
      capture      = 1'b0;
      compare      = 1'b0;
      advance      = 1'b0;

      unique case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               accept_start = 1'b1;
               next_state   = S_LOAD;
            end
         end
         S_LOAD: begin
            in_ready = !abort;
            if (in_valid) begin
               capture    = 1'b1;
               next_state = S_WRITE;
            end
         end
         S_WRITE: begin
            ram_write = 1'b1;
            if (VERIFY) next_state = S_READ;
            else        advance    = 1'b1;
         end
         S_READ: begin
            ram_read   = 1'b1;
            next_state = S_CHECK;
         end
         S_CHECK: begin
            ram_read = 1'b1;
            compare  = 1'b1;
            advance  = 1'b1;
         end
         S_DONE: begin
            done       = 1'b1;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase

      if (advance) next_state = last_addr ? S_DONE : S_LOAD;

      // Abort outranks start and normal progression; it also freezes addr, hold and error.
      if (abort) begin
         next_state   = S_IDLE;
         accept_start = 1'b0;
         capture      = 1'b0;
         compare      = 1'b0;
         advance      = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         addr     <= '0;
         hold     <= '0;
         error    <= 1'b0;
         err_addr <= '0;
      end else begin
         state <= next_state;
         if (accept_start) begin
            addr     <= '0;
            error    <= 1'b0;
            err_addr <= '0;
         end
         if (capture) hold <= in_data;
         if (compare && mismatch && !error) begin
            error    <= 1'b1;
            err_addr <= addr;
         end
         if (advance && !last_addr) addr <= addr + ADDR_W'(1);
      end
   end

endmodule
